eeg_sample_loader: RTL and testbench



---
 rtl/eeg_sample_loader_pkg.sv | 46 ++++
 rtl/eeg_sample_loader_sample_fifo.sv | 61 ++++++
 rtl/eeg_sample_loader.sv | 145 ++++++++++++++
 tb/tb_eeg_sample_loader.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/eeg_sample_loader_pkg.sv
// Shared types and constants for the EEG input loader and the int-res memory map.
package eeg_sample_loader_pkg;

   typedef logic [15:0] AdcData_t;
   typedef logic [15:0] IntResAddr_t;
   typedef logic [29:0] IntResDouble_t;

   typedef enum logic {
      SINGLE_WIDTH = 1'b0,
      DOUBLE_WIDTH = 1'b1
   } DataWidth_t;

   typedef enum logic [2:0] {
      INT_RES_SW_FX = 3'd0,
      INT_RES_DW_FX = 3'd1,
      INT_RES_SW_FX_LOW = 3'd2
   } FxFormatIntRes_t;

   // Regions of the intermediate-result memory, indexing mem_map.
   typedef enum int unsigned {
      EEG_INPUT_MEM   = 0,
      CLASS_TOKEN_MEM = 1,
      POS_EMB_MEM     = 2,
      ENC_OUT_MEM     = 3
   } IntResMem_t;

   localparam int unsigned NUM_INT_RES_MEM = 4;
   localparam int unsigned mem_map [NUM_INT_RES_MEM] = '{0, 3840, 3904, 4160};

   localparam int unsigned NUM_PATCHES           = 60;
   localparam int unsigned PATCH_LEN             = 64;
   localparam int unsigned EEG_NUM_SAMPLES       = NUM_PATCHES * PATCH_LEN;
   localparam int unsigned EEG_LOADER_FIFO_DEPTH = 2;

   typedef enum logic [1:0] {
      IDLE_LOAD = 2'd0,
      LOAD      = 2'd1,
      DRAIN     = 2'd2
   } EegLoaderState_t;

   // Unsigned 16b sample to Q10.20: value = sample / 65536, never negative, exact.
   function automatic IntResDouble_t adc_to_int_res_dw(input AdcData_t sample);
      return {10'b0, sample, 4'b0};
   endfunction

endpackage

// File: rtl/eeg_sample_loader_sample_fifo.sv
// Small synchronous FIFO with registered head; accepts push+pop when full.
module sample_fifo #(
   parameter int unsigned WIDTH = 30,
   parameter int unsigned DEPTH = 2
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       push_i,
   input  logic [WIDTH-1:0]           wdata_i,
   input  logic                       pop_i,
   output logic [WIDTH-1:0]           rdata_o,
   output logic                       full_o,
   output logic                       empty_o,
   output logic [$clog2(DEPTH):0]     count_o
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH) + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q;
   logic [AW-1:0]    rd_ptr_q;
   logic [CW-1:0]    count_q;
   logic             push_ok;
   logic             pop_ok;

   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == CW'(DEPTH));
   assign count_o = count_q;
   assign rdata_o = mem_q[rd_ptr_q];

   // A push into a full buffer is only legal when the head leaves the same cycle.
   assign pop_ok  = pop_i & ~empty_o;
   assign push_ok = push_i & (~full_o | pop_ok);

   // Storage, pointers and occupancy.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_ok) begin
            mem_q[wr_ptr_q] <= wdata_i;
            wr_ptr_q        <= wr_ptr_q + AW'(1);
         end
         if (pop_ok) begin
            rd_ptr_q <= rd_ptr_q + AW'(1);
         end
         case ({push_ok, pop_ok})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/eeg_sample_loader.sv
// Writes one inference window of ADC samples into the EEG_INPUT_MEM int-res region.
module eeg_sample_loader
   import eeg_sample_loader_pkg::*;
#(
   parameter int unsigned NUM_SAMPLES = EEG_NUM_SAMPLES,
   parameter int unsigned BASE_ADDR   = mem_map[EEG_INPUT_MEM],
   parameter int unsigned FIFO_DEPTH  = EEG_LOADER_FIFO_DEPTH
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic            adc_valid,
   input  AdcData_t        adc_data,
   output logic            mem_req,
   output IntResAddr_t     mem_addr,
   output IntResDouble_t   mem_data,
   output DataWidth_t      mem_width,
   output FxFormatIntRes_t mem_format,
   input  logic            mem_gnt,
   output logic            busy,
   output logic            done,
   output logic            overrun,
   output logic [11:0]     sample_count
);

   localparam int unsigned CW       = $clog2(FIFO_DEPTH) + 1;
   localparam IntResAddr_t BASE     = IntResAddr_t'(BASE_ADDR);
   localparam logic [11:0] NUM_LAST = 12'(NUM_SAMPLES - 1);

   if ((NUM_SAMPLES > mem_map[CLASS_TOKEN_MEM] - BASE_ADDR) || (NUM_SAMPLES == 0)
       || (NUM_SAMPLES > 4095)) begin : g_bad_num_samples
      $error("eeg_sample_loader: NUM_SAMPLES does not fit in the EEG_INPUT_MEM region");
   end

   EegLoaderState_t state_q, state_d;
   logic [11:0]     accepted_q, accepted_d;
   logic [11:0]     sample_count_q, sample_count_d;
   IntResAddr_t     mem_addr_q, mem_addr_d;
   logic            overrun_q, overrun_d;
   logic            done_q, done_d;

   logic            fifo_full;
   logic            fifo_empty;
   logic [CW-1:0]   fifo_count;
   logic            pop;
   logic            push;
   logic            drop;
   logic            sample_slot;

   assign mem_req      = ~fifo_empty;
   assign mem_addr     = mem_addr_q;
   assign mem_width    = DOUBLE_WIDTH;
   assign mem_format   = INT_RES_DW_FX;
   assign busy         = (state_q != IDLE_LOAD);
   assign done         = done_q;
   assign overrun      = overrun_q;
   assign sample_count = sample_count_q;

   assign pop         = mem_req & mem_gnt;
   assign sample_slot = (state_q == LOAD) & adc_valid;
   assign push        = sample_slot & (~fifo_full | pop);
   assign drop        = sample_slot & fifo_full & ~pop;

   sample_fifo #(
      .WIDTH ($bits(IntResDouble_t)),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i   (clk),
      .rst_i   (rst),
      .push_i  (push),
      .wdata_i (adc_to_int_res_dw(adc_data)),
      .pop_i   (pop),
      .rdata_o (mem_data),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_count)
   );

   // State and counter registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= IDLE_LOAD;
         accepted_q     <= '0;
         sample_count_q <= '0;
         mem_addr_q     <= BASE;
         overrun_q      <= 1'b0;
         done_q         <= 1'b0;
      end else begin
         state_q        <= state_d;
         accepted_q     <= accepted_d;
         sample_count_q <= sample_count_d;
         mem_addr_q     <= mem_addr_d;
         overrun_q      <= overrun_d;
         done_q         <= done_d;
      end
   end

   // Next-state: accept samples until the window is full, then drain the buffer.
   always_comb begin
      state_d        = state_q;
      accepted_d     = accepted_q;
      sample_count_d = sample_count_q;
      mem_addr_d     = mem_addr_q;
      overrun_d      = overrun_q;
      done_d         = 1'b0;

      if (pop) begin
         sample_count_d = sample_count_q + 12'd1;
         mem_addr_d     = mem_addr_q + 16'd1;
      end

      case (state_q)
         IDLE_LOAD: begin
            if (start) begin
               state_d        = LOAD;
               accepted_d     = '0;
               sample_count_d = '0;
               mem_addr_d     = BASE;
               overrun_d      = 1'b0;
            end
         end
         LOAD: begin
            if (push) begin
               accepted_d = accepted_q + 12'd1;
               if (accepted_q == NUM_LAST) begin
                  state_d = DRAIN;
               end
            end
            if (drop) begin
               overrun_d = 1'b1;
            end
         end
         DRAIN: begin
            if (pop && (fifo_count == CW'(1))) begin
               state_d = IDLE_LOAD;
               done_d  = 1'b1;
            end
         end
         default: begin
            state_d = IDLE_LOAD;
         end
      endcase
   end

endmodule

// File: tb/tb_eeg_sample_loader.sv
// Self-checking bench for eeg_sample_loader against a queue-based reference model.
module tb_eeg_sample_loader;
   import eeg_sample_loader_pkg::*;

   localparam int unsigned N = 8;

   logic            clk = 1'b0;
   logic            rst;
   logic            start;
   logic            adc_valid;
   AdcData_t        adc_data;
   logic            mem_req;
   IntResAddr_t     mem_addr;
   IntResDouble_t   mem_data;
   DataWidth_t      mem_width;
   FxFormatIntRes_t mem_format;
   logic            mem_gnt;
   logic            busy;
   logic            done;
   logic            overrun;
   logic [11:0]     sample_count;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: buffer contents, phase flags, counters.
   logic [29:0] q[$];
   bit          m_loading;
   bit          m_draining;
   bit          m_done;
   bit          m_overrun;
   int unsigned m_accepted;
   int unsigned m_written;

   always #5 clk = ~clk;

   eeg_sample_loader #(
      .NUM_SAMPLES (N),
      .BASE_ADDR   (0),
      .FIFO_DEPTH  (2)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .adc_valid    (adc_valid),
      .adc_data     (adc_data),
      .mem_req      (mem_req),
      .mem_addr     (mem_addr),
      .mem_data     (mem_data),
      .mem_width    (mem_width),
      .mem_format   (mem_format),
      .mem_gnt      (mem_gnt),
      .busy         (busy),
      .done         (done),
      .overrun      (overrun),
      .sample_count (sample_count)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      q.delete();
      m_loading  = 0;
      m_draining = 0;
      m_done     = 0;
      m_overrun  = 0;
      m_accepted = 0;
      m_written  = 0;
   endtask

   task automatic check_outputs();
      chk("mem_req", {31'd0, mem_req}, {31'd0, q.size() != 0});
      chk("mem_addr", {16'd0, mem_addr}, m_written);
      if (q.size() != 0) chk("mem_data", {2'd0, mem_data}, {2'd0, q[0]});
      chk("busy", {31'd0, busy}, {31'd0, m_loading | m_draining});
      chk("done", {31'd0, done}, {31'd0, m_done});
      chk("overrun", {31'd0, overrun}, {31'd0, m_overrun});
      chk("sample_count", {20'd0, sample_count}, m_written);
   endtask

   // One clock of the specified behaviour, applied to the model.
   task automatic model_step(input bit st, input bit v, input logic [15:0] d, input bit g);
      bit was_idle, was_load, was_drain, popped;
      was_idle  = !m_loading && !m_draining;
      was_load  = m_loading;
      was_drain = m_draining;
      m_done    = 0;
      popped    = (q.size() != 0) && g;
      if (popped) begin
         void'(q.pop_front());
         m_written++;
      end
      if (was_load && v) begin
         if (q.size() < 2) begin
            q.push_back(30'(32'(d) * 16));
            m_accepted++;
         end else begin
            m_overrun = 1;
         end
      end
      if (was_load && m_accepted == N) begin
         m_loading  = 0;
         m_draining = 1;
      end
      if (was_drain && popped && q.size() == 0) begin
         m_draining = 0;
         m_done     = 1;
      end
      if (was_idle && st) begin
         m_loading  = 1;
         m_accepted = 0;
         m_written  = 0;
         m_overrun  = 0;
      end
   endtask

   task automatic cyc(input bit st, input bit v, input logic [15:0] d, input bit g);
      start     = st;
      adc_valid = v;
      adc_data  = d;
      mem_gnt   = g;
      check_outputs();
      model_step(st, v, d, g);
      @(posedge clk);
      #1;
      start     = 1'b0;
      adc_valid = 1'b0;
   endtask

   task automatic run_random(input int vprob, input int gprob);
      int budget;
      budget = 400;
      while ((m_loading || m_draining) && budget > 0) begin
         cyc($urandom_range(0, 19) == 0, $urandom_range(0, 99) < vprob,
             16'($urandom), $urandom_range(0, 99) < gprob);
         budget--;
      end
      chk("load_completes", {31'd0, busy}, 32'd0);
   endtask

   initial begin
      int budget;
      rst       = 1'b1;
      start     = 1'b0;
      adc_valid = 1'b0;
      adc_data  = '0;
      mem_gnt   = 1'b0;
      model_reset();
      #12;
      chk("reset_mem_data", {2'd0, mem_data}, 32'd0);
      chk("mem_width", {31'd0, mem_width}, {31'd0, DOUBLE_WIDTH});
      chk("mem_format", {29'd0, mem_format}, {29'd0, INT_RES_DW_FX});
      check_outputs();
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Samples in IDLE are ignored.
      repeat (3) cyc(0, 1, 16'($urandom), 1);

      // Basic load, data 0..7, grant always high.
      cyc(1, 0, 0, 1);
      for (int i = 0; i < 8; i++) cyc(0, 1, 16'(i), 1);
      repeat (4) cyc(0, 0, 0, 1);
      chk("basic_count", {20'd0, sample_count}, 32'd8);

      // Conversion extremes, then stall and overrun.
      cyc(1, 0, 0, 0);
      cyc(0, 1, 16'hFFFF, 0);
      chk("conv_ffff", {2'd0, mem_data}, 32'h000FFFF0);
      cyc(0, 1, 16'h8000, 0);
      cyc(0, 1, 16'h1234, 0);
      chk("overrun_after_C", {31'd0, overrun}, 32'd1);
      cyc(0, 0, 0, 1);
      chk("conv_8000", {2'd0, mem_data}, 32'h00080000);
      run_random(60, 50);
      cyc(0, 0, 0, 1);

      // Restart clears overrun and address; full buffer push+pop is not an overrun.
      cyc(1, 0, 0, 0);
      chk("restart_overrun", {31'd0, overrun}, 32'd0);
      chk("restart_addr", {16'd0, mem_addr}, 32'd0);
      cyc(0, 1, 16'($urandom), 0);
      cyc(0, 1, 16'($urandom), 0);
      cyc(0, 1, 16'($urandom), 1);
      chk("full_push_pop_no_overrun", {31'd0, overrun}, 32'd0);
      // start during LOAD must not clear counters.
      cyc(1, 1, 16'($urandom), 1);
      chk("start_in_load_count", {20'd0, sample_count}, 32'd2);
      run_random(70, 80);
      cyc(0, 0, 0, 1);

      // Randomized loads.
      for (int k = 0; k < 6; k++) begin
         cyc(1, 0, 0, 1);
         run_random(30 + 10 * k, 90 - 10 * k);
         cyc(0, 0, 0, 1);
      end

      // Asynchronous reset mid-load after three writes.
      cyc(1, 0, 0, 1);
      budget = 50;
      while (m_written < 3 && budget > 0) begin
         cyc(0, 1, 16'($urandom), 1);
         budget--;
      end
      chk("three_writes", {20'd0, sample_count}, 32'd3);
      #2 rst = 1'b1;
      #1;
      model_reset();
      chk("async_rst_busy", {31'd0, busy}, 32'd0);
      chk("async_rst_req", {31'd0, mem_req}, 32'd0);
      chk("async_rst_data", {2'd0, mem_data}, 32'd0);
      check_outputs();
      #1 rst = 1'b0;
      @(posedge clk);
      #1;
      cyc(0, 0, 0, 1);
      cyc(1, 0, 0, 1);
      chk("post_reset_addr", {16'd0, mem_addr}, 32'd0);
      run_random(80, 70);
      cyc(0, 0, 0, 1);
      cyc(0, 0, 0, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
